// File: rtl/beat_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : beat_pkg
//  Description : Shared types and constants for the beat recorder/player.
//  Revision    : 1.0 - initial release
// ============================================================================
package beat_pkg;

  // log2 of notes per slot (64 notes per slot)
  localparam int ADDR_W  = 6;
  // note width: keyboard ASCII code
  localparam int NOTE_W  = 7;
  // note value meaning "no sound"
  localparam int SILENCE = 0;

  // controller mode, also driven straight onto the mode output
  typedef enum logic [1:0] {
    MODE_IDLE   = 2'b00,
    MODE_RECORD = 2'b01,
    MODE_PLAY   = 2'b10
  } mode_e;

endpackage
`default_nettype wire

// File: rtl/beat_record_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : beat_record_ctrl_if
//  Description : Keyboard/switch inputs, note-RAM bus and player outputs of
//                the beat recorder, bundled for port connection.
//  Revision    : 1.0 - initial release
// ============================================================================
interface beat_record_ctrl_if #(
  parameter int ADDR_W = beat_pkg::ADDR_W,
  parameter int NOTE_W = beat_pkg::NOTE_W
);
  logic [NOTE_W-1:0] ascii;
  logic              tick;
  logic [1:0]        toggle;
  logic              record;
  logic [ADDR_W:0]   ram_addr;
  logic [NOTE_W-1:0] ram_wdata;
  logic              ram_we;
  logic [NOTE_W-1:0] ram_rdata;
  logic [NOTE_W-1:0] play_ascii1;
  logic [NOTE_W-1:0] play_ascii2;
  logic [1:0]        mode;
  logic [1:0]        slot_valid;

  // controller side: owns the RAM bus and the player outputs
  modport master (
    input  ascii, tick, toggle, record, ram_rdata,
    output ram_addr, ram_wdata, ram_we, play_ascii1, play_ascii2, mode, slot_valid
  );

  // environment side: keyboard, switches and the note RAM
  modport slave (
    output ascii, tick, toggle, record, ram_rdata,
    input  ram_addr, ram_wdata, ram_we, play_ascii1, play_ascii2, mode, slot_valid
  );
endinterface
`default_nettype wire

// File: rtl/beat_slot_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : beat_slot_ctr
//  Description : Per-slot bookkeeping: recorded length, valid flag and the
//                wrapping playback pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
module beat_slot_ctr
  import beat_pkg::*;
#(
  parameter int ADDR_W = beat_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,       // a new recording into this slot starts
  input  logic              load,      // the recording into this slot ended
  input  logic [ADDR_W:0]   load_len,  // number of notes captured (0..64)
  input  logic              sel,       // slot-select switch for this slot
  input  logic              adv,       // a fetch from this slot was issued
  output logic              valid,
  output logic              active,
  output logic [ADDR_W-1:0] ptr
);

  logic [ADDR_W:0] len;
  logic [ADDR_W:0] ptr_inc;

  assign active  = sel & valid;
  assign ptr_inc = {1'b0, ptr} + (ADDR_W+1)'(1);

  // length/valid bookkeeping and pointer that wraps at the recorded length
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len   <= '0;
      valid <= 1'b0;
      ptr   <= '0;
    end else if (clr) begin
      len   <= '0;
      valid <= 1'b0;
      ptr   <= '0;
    end else if (load) begin
      len   <= load_len;
      valid <= |load_len;
      ptr   <= '0;
    end else if (!active) begin
      ptr   <= '0;
    end else if (adv) begin
      ptr   <= (ptr_inc == len) ? '0 : ptr_inc[ADDR_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/beat_record_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : beat_record_ctrl
//  Description : Two-slot beat recorder. Records live notes into a shared
//                note RAM and plays saved slots back, one note per tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module beat_record_ctrl
  import beat_pkg::*;
#(
  parameter int ADDR_W = beat_pkg::ADDR_W,
  parameter int NOTE_W = beat_pkg::NOTE_W
) (
  input  logic               clk,
  input  logic               reset,
  beat_record_ctrl_if.master bus
);

  // fetch sequencer: which RAM access is on the bus / returning this cycle
  localparam logic [1:0] PH_IDLE  = 2'd0;
  localparam logic [1:0] PH_ADDR0 = 2'd1;  // slot 0 address presented
  localparam logic [1:0] PH_ADDR1 = 2'd2;  // slot 1 address, slot 0 data back
  localparam logic [1:0] PH_DATA1 = 2'd3;  // slot 1 data back

  mode_e             state, state_nxt;
  logic              rec_slot;
  logic [ADDR_W-1:0] idx;
  logic              rec_full;
  logic              rec_armed;
  logic [1:0]        phase;
  logic              fetch0, fetch1;
  logic [ADDR_W:0]   addr_q;
  logic [NOTE_W-1:0] wdata_q;
  logic              we_q;
  logic [NOTE_W-1:0] play0_q, play1_q;
  logic              valid0, valid1, active0, active1;
  logic [ADDR_W-1:0] ptr0, ptr1;
  logic              rec_go, tgt_slot, any_active;
  logic              enter_rec, rec_end, rec_tick, play_tick, slot1_turn;
  logic [ADDR_W:0]   rec_len;

  assign rec_go     = bus.record && (bus.toggle != 2'b00) && rec_armed;
  assign tgt_slot   = ~bus.toggle[0];           // slot 0 wins when both set
  assign any_active = active0 | active1;
  assign enter_rec  = (state != MODE_RECORD) && (state_nxt == MODE_RECORD);
  assign rec_end    = (state == MODE_RECORD) && (state_nxt != MODE_RECORD);
  assign rec_tick   = (state == MODE_RECORD) && (state_nxt == MODE_RECORD) && bus.tick;
  // a tick is taken only when no fetch is pending on the RAM bus
  assign play_tick  = (state == MODE_PLAY) && (state_nxt == MODE_PLAY) && bus.tick &&
                      ((phase == PH_IDLE) || (phase == PH_DATA1));
  assign slot1_turn = (state_nxt == MODE_PLAY) && (phase == PH_ADDR0);
  // after the 64th write idx has wrapped to 0, so this reads as 64
  assign rec_len    = {rec_full, idx};

  // mode state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= MODE_IDLE;
    else       state <= state_nxt;
  end

  // mode transitions; record requests win over playback
  always_comb begin
    state_nxt = MODE_IDLE;
    case (state)
      MODE_IDLE: begin
        if (rec_go)                         state_nxt = MODE_RECORD;
        else if (!bus.record && any_active) state_nxt = MODE_PLAY;
        else                                state_nxt = MODE_IDLE;
      end
      MODE_RECORD: state_nxt = (!bus.record || rec_full) ? MODE_IDLE : MODE_RECORD;
      MODE_PLAY: begin
        if (rec_go)           state_nxt = MODE_RECORD;
        else if (!any_active) state_nxt = MODE_IDLE;
        else                  state_nxt = MODE_PLAY;
      end
      default: state_nxt = MODE_IDLE;
    endcase
  end

  // recording target, write index and full flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rec_slot <= 1'b0;
      idx      <= '0;
      rec_full <= 1'b0;
    end else if (enter_rec) begin
      rec_slot <= tgt_slot;
      idx      <= '0;
      rec_full <= 1'b0;
    end else if (rec_tick) begin
      idx <= idx + ADDR_W'(1);
      if (&idx) rec_full <= 1'b1;
    end
  end

  // a full slot blocks re-recording until the button is released
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                 rec_armed <= 1'b1;
    else if (!bus.record)                      rec_armed <= 1'b1;
    else if (state == MODE_RECORD && rec_full) rec_armed <= 1'b0;
  end

  // fetch sequencer; any exit from playback aborts the pending fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase  <= PH_IDLE;
      fetch0 <= 1'b0;
      fetch1 <= 1'b0;
    end else if (state_nxt != MODE_PLAY) begin
      phase  <= PH_IDLE;
      fetch0 <= 1'b0;
      fetch1 <= 1'b0;
    end else if (play_tick) begin
      phase  <= PH_ADDR0;
      fetch0 <= active0;
    end else if (phase == PH_ADDR0) begin
      phase  <= PH_ADDR1;
      fetch1 <= active1;
    end else if (phase == PH_ADDR1) begin
      phase  <= PH_DATA1;
    end else begin
      phase  <= PH_IDLE;
    end
  end

  // RAM bus: one-cycle write strobe when recording, slot addresses on fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      if (rec_tick) begin
        addr_q  <= {rec_slot, idx};
        wdata_q <= bus.ascii;
        we_q    <= 1'b1;
      end else if (play_tick && active0) begin
        addr_q  <= {1'b0, ptr0};
      end else if (slot1_turn && active1) begin
        addr_q  <= {1'b1, ptr1};
      end
    end
  end

  // player outputs: capture returned notes, silence inactive slots
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      play0_q <= '0;
      play1_q <= '0;
    end else begin
      if (!active0)                       play0_q <= NOTE_W'(SILENCE);
      else if (phase == PH_ADDR1 && fetch0) play0_q <= bus.ram_rdata;
      if (!active1)                       play1_q <= NOTE_W'(SILENCE);
      else if (phase == PH_DATA1 && fetch1) play1_q <= bus.ram_rdata;
    end
  end

  beat_slot_ctr #(.ADDR_W(ADDR_W)) u_slot0 (
    .clk      (clk),
    .reset    (reset),
    .clr      (enter_rec && !tgt_slot),
    .load     (rec_end && !rec_slot),
    .load_len (rec_len),
    .sel      (bus.toggle[0]),
    .adv      (play_tick && active0),
    .valid    (valid0),
    .active   (active0),
    .ptr      (ptr0)
  );

  beat_slot_ctr #(.ADDR_W(ADDR_W)) u_slot1 (
    .clk      (clk),
    .reset    (reset),
    .clr      (enter_rec && tgt_slot),
    .load     (rec_end && rec_slot),
    .load_len (rec_len),
    .sel      (bus.toggle[1]),
    .adv      (slot1_turn && active1),
    .valid    (valid1),
    .active   (active1),
    .ptr      (ptr1)
  );

  assign bus.ram_addr    = addr_q;
  assign bus.ram_wdata   = wdata_q;
  assign bus.ram_we      = we_q;
  assign bus.play_ascii1 = play0_q;
  assign bus.play_ascii2 = play1_q;
  assign bus.mode        = state;
  assign bus.slot_valid  = {valid1, valid0};

endmodule
`default_nettype wire

// File: tb/tb_beat_record_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_beat_record_ctrl
//  Description : Self-checking bench for beat_record_ctrl with a note-RAM
//                model and a queue-based model of the recorded slots.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_beat_record_ctrl;
  import beat_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  // model: recorded notes per slot, play pointers, expected player outputs
  int notes [2][$];
  int mptr  [2];
  int exp_play [2];
  int fixed_q [$];

  // writes observed on the RAM bus
  int wr_addr_q [$];
  int wr_data_q [$];

  logic [NOTE_W-1:0] mem [0:(1<<(ADDR_W+1))-1];

  beat_record_ctrl_if bus ();

  beat_record_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // synchronous note RAM, read data one cycle after the address
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  // write logger
  always @(posedge clk) begin
    if (bus.ram_we) begin
      wr_addr_q.push_back(int'(bus.ram_addr));
      wr_data_q.push_back(int'(bus.ram_wdata));
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_tick(input int note);
    bus.ascii = NOTE_W'(note);
    bus.tick  = 1'b1;
    @(negedge clk);
    bus.tick  = 1'b0;
    bus.ascii = '0;
  endtask

  function automatic int exp_valid();
    return ((notes[1].size() > 0) ? 2 : 0) + ((notes[0].size() > 0) ? 1 : 0);
  endfunction

  // record n ticks into the slot chosen by tog, then release everything
  task automatic do_record(input logic [1:0] tog, input int n, input int gap);
    int s;
    int v;
    int nexp;
    s = tog[0] ? 0 : 1;
    wr_addr_q.delete();
    wr_data_q.delete();
    bus.toggle = tog;
    bus.record = 1'b1;
    @(negedge clk);
    check_eq("rec_enter_mode", int'(bus.mode), int'(MODE_RECORD));
    notes[s].delete();
    check_eq("rec_slot_cleared", int'(bus.slot_valid), exp_valid());
    for (int i = 0; i < n; i++) begin
      v = (i < fixed_q.size()) ? fixed_q[i] : int'($urandom_range(1, 127));
      pulse_tick(v);
      if (i < 64) notes[s].push_back(v);
      if (i == 63) begin
        check_eq("we_on_64th", int'(bus.ram_we), 1);
        @(negedge clk);
        check_eq("mode_after_64th", int'(bus.mode), int'(MODE_IDLE));
      end
      repeat (gap) @(negedge clk);
    end
    if (n > 64) check_eq("no_rearm_while_held", int'(bus.mode), int'(MODE_IDLE));
    bus.record = 1'b0;
    bus.toggle = 2'b00;
    repeat (2) @(negedge clk);
    nexp = (n > 64) ? 64 : n;
    check_eq("wr_count", wr_addr_q.size(), nexp);
    for (int i = 0; i < nexp && i < wr_addr_q.size(); i++) begin
      check_eq("wr_addr", wr_addr_q[i], s * 64 + i);
      check_eq("wr_data", wr_data_q[i], notes[s][i]);
    end
    check_eq("slot_valid_after_rec", int'(bus.slot_valid), exp_valid());
    check_eq("mode_after_rec", int'(bus.mode), int'(MODE_IDLE));
    mptr[0] = 0;
    mptr[1] = 0;
  endtask

  // play nticks; gap < 0 picks a random spacing, dbl adds a tick during the fetch
  task automatic do_play(input logic [1:0] tog, input int nticks, input bit dbl, input int gap);
    bit a0, a1;
    int p0, p1;
    a0 = tog[0] && (notes[0].size() > 0);
    a1 = tog[1] && (notes[1].size() > 0);
    exp_play[0] = 0;
    exp_play[1] = 0;
    bus.toggle = tog;
    bus.record = 1'b0;
    @(negedge clk);
    check_eq("play_mode", int'(bus.mode), (a0 || a1) ? int'(MODE_PLAY) : int'(MODE_IDLE));
    for (int t = 0; t < nticks; t++) begin
      p0 = mptr[0];
      p1 = mptr[1];
      pulse_tick(int'($urandom_range(1, 127)));
      check_eq("fetch_addr0", int'(bus.ram_addr), a0 ? p0 : 0);
      if (dbl) bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
      check_eq("fetch_addr1", int'(bus.ram_addr), a1 ? 64 + p1 : 0);
      check_eq("play1_hold", int'(bus.play_ascii1), exp_play[0]);
      @(negedge clk);
      if (a0) begin
        exp_play[0] = notes[0][p0];
        mptr[0] = (p0 + 1) % notes[0].size();
      end
      check_eq("play1_note", int'(bus.play_ascii1), exp_play[0]);
      check_eq("play2_hold", int'(bus.play_ascii2), exp_play[1]);
      @(negedge clk);
      if (a1) begin
        exp_play[1] = notes[1][p1];
        mptr[1] = (p1 + 1) % notes[1].size();
      end
      check_eq("play2_note", int'(bus.play_ascii2), exp_play[1]);
      repeat ((gap < 0) ? int'($urandom_range(0, 3)) : gap) @(negedge clk);
    end
    bus.toggle = 2'b00;
    repeat (2) @(negedge clk);
    check_eq("play1_silenced", int'(bus.play_ascii1), 0);
    check_eq("play2_silenced", int'(bus.play_ascii2), 0);
    check_eq("mode_after_play", int'(bus.mode), int'(MODE_IDLE));
    mptr[0] = 0;
    mptr[1] = 0;
  endtask

  initial begin
    for (int i = 0; i < (1 << (ADDR_W + 1)); i++) mem[i] = '0;
    mptr[0] = 0;
    mptr[1] = 0;
    reset      = 1'b1;
    bus.ascii  = '0;
    bus.tick   = 1'b0;
    bus.toggle = 2'b00;
    bus.record = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_mode", int'(bus.mode), int'(MODE_IDLE));
    check_eq("rst_slot_valid", int'(bus.slot_valid), 0);
    check_eq("rst_ram_we", int'(bus.ram_we), 0);
    check_eq("rst_ram_addr", int'(bus.ram_addr), 0);
    check_eq("rst_ram_wdata", int'(bus.ram_wdata), 0);
    check_eq("rst_play1", int'(bus.play_ascii1), 0);
    check_eq("rst_play2", int'(bus.play_ascii2), 0);
    reset = 1'b0;
    @(negedge clk);

    // slot 0: 'a','s','d' then play seven ticks eight cycles apart
    fixed_q = '{97, 115, 100};
    do_record(2'b01, 3, 1);
    fixed_q.delete();
    do_play(2'b01, 7, 1'b0, 4);

    // slot 1 with two notes, then both slots with dropped in-flight ticks
    do_record(2'b10, 2, 1);
    do_play(2'b11, 6, 1'b1, -1);

    // both switches on while recording: slot 0 only, slot 1 untouched
    do_record(2'b11, 4, 0);
    do_play(2'b10, 5, 1'b0, 2);
    do_play(2'b11, 5, 1'b0, -1);

    // held record stops at 64 notes; pointer wraps at 64
    do_record(2'b01, 70, 1);
    do_play(2'b01, 66, 1'b0, 0);

    // re-press after release starts a fresh recording
    do_record(2'b01, 3, 0);

    // reset in the middle of a recording
    bus.toggle = 2'b01;
    bus.record = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) pulse_tick(int'($urandom_range(1, 127)));
    reset = 1'b1;
    #1;
    check_eq("midrec_rst_mode", int'(bus.mode), int'(MODE_IDLE));
    check_eq("midrec_rst_we", int'(bus.ram_we), 0);
    check_eq("midrec_rst_addr", int'(bus.ram_addr), 0);
    check_eq("midrec_rst_wdata", int'(bus.ram_wdata), 0);
    check_eq("midrec_rst_valid", int'(bus.slot_valid), 0);
    check_eq("midrec_rst_play1", int'(bus.play_ascii1), 0);
    check_eq("midrec_rst_play2", int'(bus.play_ascii2), 0);
    notes[0].delete();
    notes[1].delete();
    @(negedge clk);
    reset      = 1'b0;
    bus.record = 1'b0;
    bus.toggle = 2'b01;
    repeat (3) @(negedge clk);
    check_eq("post_rst_no_play", int'(bus.mode), int'(MODE_IDLE));
    check_eq("post_rst_valid", int'(bus.slot_valid), 0);
    bus.toggle = 2'b00;
    @(negedge clk);

    // recording is armed again after reset
    do_record(2'b10, 3, 1);
    do_play(2'b10, 4, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/beat_record_ctrl.md
BEAT_RECORD_CTRL -- requirements
Module: beat_record_ctrl

Interface
REQ-001 Parameter: ADDR_W, 6, log2 of entries per slot (64 notes per slot).
REQ-002 Parameter: NOTE_W, 7, note width (keyboard ASCII code).
REQ-003 Port: clk  in  1  sole clock; all state on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: ascii  in  NOTE_W  live keyboard note; 0 = silence.
REQ-006 Port: tick  in  1  one-cycle sample-rate pulse (one note per tick).
REQ-007 Port: toggle  in  2  slot-select switches; bit0 = slot 0, bit1 = slot 1.
REQ-008 Port: record  in  1  record button level, synchronous to clk, 1 = record.
REQ-009 Port: ram_addr  out  ADDR_W+1  shared note-RAM address {slot, index}.
REQ-010 Port: ram_wdata  out  NOTE_W  RAM write data.
REQ-011 Port: ram_we  out  1  RAM write enable.
REQ-012 Port: ram_rdata  in  NOTE_W  RAM read data, valid the cycle after the address is presented.
REQ-013 Port: play_ascii1 / play_ascii2  out  NOTE_W each  notes for saved-slot buzzers 0/1.
REQ-014 Port: mode  out  2  00 IDLE, 01 RECORD, 10 PLAYBACK.
REQ-015 Port: slot_valid  out  2  slot holds a recording of length >= 1.

Function
REQ-016 Mode FSM SHALL have exactly three states: IDLE, RECORD, PLAYBACK; 11 is unreachable and SHALL recover to IDLE.
REQ-017 Record slot SHALL be 0 if toggle[0]=1, else 1 if toggle[1]=1; both on -> slot 0 only.
REQ-018 IDLE/PLAYBACK -> RECORD when record=1, toggle!=0 and rec_armed=1; record has priority over playback.
REQ-019 Entering RECORD SHALL clear the target slot's length, valid bit and play pointer, and abort any in-flight fetch.
REQ-020 In RECORD, each tick SHALL write ascii (sampled at the tick edge) to {slot, idx}, with ram_we high for exactly the next cycle, then idx+1.
REQ-021 RECORD -> IDLE when record=0: length=idx, valid=(idx!=0).
REQ-022 RECORD -> IDLE when the 64th write completes: length=64, valid=1, rec_armed=0; rec_armed returns to 1 only after record=0.
REQ-023 Toggle changes during RECORD SHALL NOT change the target slot.
REQ-024 Slot k is active when toggle[k]=1 and slot_valid[k]=1.
REQ-025 IDLE -> PLAYBACK when record=0 and any slot is active; PLAYBACK -> IDLE when no slot is active.
REQ-026 On a PLAYBACK tick at edge E0, the arbiter SHALL present {0,ptr0} in the cycle after E0 and {1,ptr1} in the following cycle, skipping inactive slots without compressing timing.
REQ-027 play_ascii1 SHALL update at E2 and play_ascii2 at E3.
REQ-028 Ticks arriving while a fetch is in flight (E1, E2) SHALL be dropped.
REQ-029 After each fetch, ptr SHALL increment and wrap to 0 when ptr+1 = length.
REQ-030 An inactive slot SHALL drive play_ascii = 0 from the next cycle, and its pointer SHALL reset to 0.
REQ-031 ram_we=0 outside RECORD; ram_addr and ram_wdata SHALL be 0 when idle.
REQ-032 Length counters SHALL be ADDR_W+1 bits wide (0..64); the index SHALL be ADDR_W bits.

Reset
REQ-033 Reset SHALL force: mode=IDLE, lengths=0, slot_valid=00, pointers=0, idx=0, play_ascii1/2=0, ram_we=0, ram_addr=0, ram_wdata=0, rec_armed=1.
REQ-034 Reset mid-RECORD or mid-fetch SHALL discard the partial recording and any pending read; RAM contents are not cleared.

Structure
REQ-035 Shared package beat_pkg SHALL hold: mode enum, NOTE_W, ADDR_W, SILENCE=0.
REQ-036 One sub-module, beat_slot_ctr (length, valid, play pointer and wrap per slot), SHALL be instantiated twice; the mode FSM and RAM arbiter stay in the top level.

Verification
REQ-037 Record slot 0: toggle=01, record=1, ticks with ascii 'a','s','d', then record=0 -> three writes to addr 0,1,2; slot_valid=01; length0=3.
REQ-038 Playback slot 0 (toggle=01, record=0), 7 ticks spaced 8 cycles -> play_ascii1 sequence a,s,d,a,s,d,a; each update 2 cycles after its tick.
REQ-039 Both slots (len 3 and len 2), toggle=11 -> addr {0,p0} then {1,p1} on consecutive cycles; play_ascii2 updates one cycle after play_ascii1; ticks 1 cycle apart -> second tick dropped.
REQ-040 Record held for 70 ticks -> exactly 64 writes; mode=IDLE after the 64th; no new RECORD until record is released and re-pressed.
REQ-041 toggle=11 + record -> writes only to slot 0 addresses (0..63); slot 1 length is unchanged.
REQ-042 Reset asserted mid-RECORD after 5 writes -> all outputs at reset values; slot_valid=00; next playback request stays in IDLE.
